ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/core_defines.sv | 18 +
 rtl/ifetch_fifo.sv | 53 +++++
 rtl/ifetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/core_defines.sv
// Core-wide constants plus the fetch FSM encoding and buffer entry layout.
// Pure declarations: no timing or flow control of its own.
package core_defines;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer FIFO; head is visible the cycle after a push, pop and push may share a cycle.
// Pushes into a full FIFO without a same-cycle pop are dropped; flush empties it and wins over push/pop.
module ifetch_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; readers qualify the head with a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding memory request, responses buffered toward decode; head visible one cycle after the response.
// Requests stop once buffered plus outstanding reaches BUF_DEPTH; a redirect flushes and discards any in-flight response.
module ifetch_unit
    import core_defines::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] instr_addr_out,
    output logic            instr_addr_valid_out,
    input  logic            instr_ready_in,
    input  logic            instr_valid_in,
    input  logic [XLEN-1:0] instr_in,
    input  logic            redirect_valid_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    output logic            fetch_valid_out,
    input  logic            fetch_ready_in,
    output logic [XLEN-1:0] fetch_instr_out,
    output logic [XLEN-1:0] fetch_pc_out
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            discard_q, discard_d;

    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_after_push;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign pop              = fetch_valid_out && fetch_ready_in;
    assign count_after_push = count + CW'(1) - CW'(pop);
    assign push_entry       = '{pc: req_pc_q, instr: instr_in};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        discard_d = discard_q;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count < CW'(BUF_DEPTH)) state_d = ST_REQ;
            end
            ST_REQ: begin
                // A redirect never withdraws a request the memory is taking this cycle.
                if (instr_ready_in) begin
                    state_d   = ST_WAIT;
                    req_pc_d  = pc_q;
                    discard_d = redirect_valid_in;
                end
            end
            ST_WAIT: begin
                if (instr_valid_in) begin
                    discard_d = 1'b0;
                    if (discard_q || redirect_valid_in) begin
                        state_d = ST_REQ;
                    end else begin
                        push    = 1'b1;
                        pc_d    = req_pc_q + XLEN'(4);
                        state_d = (count_after_push < CW'(BUF_DEPTH)) ? ST_REQ : ST_IDLE;
                    end
                end else if (redirect_valid_in) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (redirect_valid_in) pc_d = redirect_pc_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .flush_i    (redirect_valid_in),
        .head_dat_o (head_entry),
        .count_o    (count)
    );

    assign instr_addr_valid_out = (state_q == ST_REQ);
    assign instr_addr_out       = instr_addr_valid_out ? pc_q : '0;
    assign fetch_valid_out      = (count != '0);
    assign fetch_instr_out      = fetch_valid_out ? head_entry.instr : '0;
    assign fetch_pc_out         = fetch_valid_out ? head_entry.pc : '0;

endmodule
